// File: rtl/elevator_actuator.sv
// Elevator actuator: cabin and door motor PWM drivers, door open/dwell/close
// sequencer, chime pulse stretcher and the cabin-versus-door interlock.
module elevator_actuator #(
    parameter int PWM_PERIOD       = 100,
    parameter int DOOR_MOVE_CYCLES = 200,
    parameter int DOOR_HOLD_CYCLES = 1000,
    parameter int BUZZ_CYCLES      = 50
) (
    input  logic Clk,
    input  logic Reset,
    input  logic M,
    input  logic D,
    input  logic P,
    input  logic W,
    input  logic S,
    output logic Mot0_pwm,
    output logic Mot0_dir,
    output logic Mot1_pwm,
    output logic Mot1_dir,
    output logic Buzzer,
    output logic R,
    output logic Interlock
);

    localparam int PWM_W    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int DOOR_MAX = (DOOR_MOVE_CYCLES > DOOR_HOLD_CYCLES) ? DOOR_MOVE_CYCLES : DOOR_HOLD_CYCLES;
    localparam int DOOR_W   = $clog2(DOOR_MAX + 1);
    localparam int BUZZ_W   = $clog2(BUZZ_CYCLES + 1);

    localparam logic [DOOR_W-1:0] MOVE_LOAD = DOOR_W'(DOOR_MOVE_CYCLES - 1);
    localparam logic [DOOR_W-1:0] HOLD_LOAD = DOOR_W'(DOOR_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        D_IDLE,
        D_OPENING,
        D_HOLD,
        D_READY,
        D_CLOSING
    } door_state_t;

    door_state_t       state, next_state;
    logic [DOOR_W-1:0] door_cnt, next_cnt;
    logic [1:0]        door_code, next_code;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [BUZZ_W-1:0] buzz_cnt;
    logic              m_r, d_r, p_r, w_r, s_r, s_prev;
    logic              r_q, mot0_dir_q, mot1_dir_q;
    logic [1:0]        code_r;
    logic              open_cmd, close_cmd, cab_req, cnt_zero;

    // Speed code to duty: the output is high while the free-running counter is below the threshold.
    function automatic logic pwm_level(input logic [1:0] code, input logic [PWM_W-1:0] cnt);
        logic [PWM_W-1:0] thr;
        case (code)
            2'b01:   thr = PWM_W'(PWM_PERIOD / 4);
            2'b10:   thr = PWM_W'(PWM_PERIOD / 2);
            2'b11:   thr = PWM_W'(3 * PWM_PERIOD / 4);
            default: thr = '0;
        endcase
        return cnt < thr;
    endfunction

    assign code_r    = {p_r, w_r};
    assign open_cmd  = m_r & d_r & (code_r != 2'b00);
    assign close_cmd = m_r & ~d_r & (code_r != 2'b00);
    assign cab_req   = ~m_r & (code_r != 2'b00);
    assign cnt_zero  = (door_cnt == '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_r    <= 1'b0;
            d_r    <= 1'b0;
            p_r    <= 1'b0;
            w_r    <= 1'b0;
            s_r    <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            m_r    <= M;
            d_r    <= D;
            p_r    <= P;
            w_r    <= W;
            s_r    <= S;
            s_prev <= s_r;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_W'(PWM_PERIOD - 1)) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // A fresh chime edge always restarts the full pulse, even mid-pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            buzz_cnt <= '0;
        end else if (s_r && !s_prev) begin
            buzz_cnt <= BUZZ_W'(BUZZ_CYCLES);
        end else if (buzz_cnt != '0) begin
            buzz_cnt <= buzz_cnt - BUZZ_W'(1);
        end
    end

    // R is flopped from the next state so it is high exactly while the FSM sits in D_READY.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= D_IDLE;
            door_cnt   <= '0;
            door_code  <= 2'b00;
            r_q        <= 1'b0;
            mot0_dir_q <= 1'b0;
            mot1_dir_q <= 1'b0;
        end else begin
            state      <= next_state;
            door_cnt   <= next_cnt;
            door_code  <= next_code;
            r_q        <= (next_state == D_READY);
            mot0_dir_q <= Mot0_dir;
            mot1_dir_q <= Mot1_dir;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = door_cnt;
        next_code  = door_code;
        case (state)
            D_IDLE: begin
                if (open_cmd) begin
                    next_state = D_OPENING;
                    next_cnt   = MOVE_LOAD;
                    next_code  = code_r;
                end
            end
            D_OPENING: begin
                if (cnt_zero) begin
                    next_state = D_HOLD;
                    next_cnt   = HOLD_LOAD;
                end else begin
                    next_cnt = door_cnt - DOOR_W'(1);
                end
            end
            D_HOLD: begin
                if (open_cmd) begin
                    next_cnt  = HOLD_LOAD;
                    next_code = code_r;
                end else if (cnt_zero) begin
                    next_state = D_READY;
                end else begin
                    next_cnt = door_cnt - DOOR_W'(1);
                end
            end
            D_READY: begin
                if (close_cmd) begin
                    next_state = D_CLOSING;
                    next_cnt   = MOVE_LOAD;
                    next_code  = code_r;
                end else if (open_cmd) begin
                    next_state = D_HOLD;
                    next_cnt   = HOLD_LOAD;
                    next_code  = code_r;
                end
            end
            D_CLOSING: begin
                if (open_cmd) begin
                    next_state = D_OPENING;
                    next_cnt   = MOVE_LOAD;
                    next_code  = code_r;
                end else if (cnt_zero) begin
                    next_state = D_IDLE;
                end else begin
                    next_cnt = door_cnt - DOOR_W'(1);
                end
            end
            default: begin
                next_state = D_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Direction outputs fall back to their held copies whenever the motor is not driven.
    always_comb begin
        Mot0_pwm  = 1'b0;
        Mot0_dir  = mot0_dir_q;
        Mot1_pwm  = 1'b0;
        Mot1_dir  = mot1_dir_q;
        Interlock = 1'b0;
        if (cab_req) begin
            if (state == D_IDLE) begin
                Mot0_pwm = pwm_level(code_r, pwm_cnt);
                Mot0_dir = d_r;
            end else begin
                Interlock = 1'b1;
            end
        end
        case (state)
            D_OPENING: begin
                Mot1_pwm = pwm_level(door_code, pwm_cnt);
                Mot1_dir = 1'b1;
            end
            D_CLOSING: begin
                Mot1_pwm = pwm_level(door_code, pwm_cnt);
                Mot1_dir = 1'b0;
            end
            default: ;
        endcase
    end

    assign R      = r_q;
    assign Buzzer = (buzz_cnt != '0);

endmodule
